// File: rtl/latch_stim_pkg.sv
// Shared types and constants for the dlatch1 stimulus generator.
// Holds the FSM state encoding and the LFSR step function.
package latch_stim_pkg;

  localparam int unsigned LFSR_W = 16;
  localparam int unsigned DLY_W  = 3;
  localparam int unsigned DLY2_W = 2;
  localparam logic [LFSR_W-1:0] LFSR_POLY = 16'hB400;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RELEASE,
    S_DRAW,
    S_WAIT_EN,
    S_WAIT_D,
    S_DONE
  } stim_state_t;

  // Galois form, shifting right; feedback applied when the bit shifted out is 1.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    lfsr_next = (v >> 1) ^ (v[0] ? LFSR_POLY : '0);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR: loads on synchronous reset, steps only when adv is high.
module lfsr16
  import latch_stim_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [LFSR_W-1:0] load_val,
  input  logic              adv,
  output logic [LFSR_W-1:0] value
);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= load_val;
    end else if (adv) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/latch_stim_gen.sv
// Clocked d/en/rstn stimulus driver for a dlatch1 instance, with a reference
// latch model that checks the returned q every busy cycle once rstn is high.
module latch_stim_gen
  import latch_stim_pkg::*;
#(
  parameter int unsigned        NUM_ITER  = 5,
  parameter int unsigned        INIT_WAIT = 10,
  parameter int unsigned        RST_WAIT  = 10,
  parameter logic [LFSR_W-1:0]  LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       q,
  output logic       d,
  output logic       en,
  output logic       rstn,
  output logic       busy,
  output logic       done,
  output logic       mismatch,
  output logic [7:0] err_count
);

  localparam int unsigned       WCNT_W    = 16;
  localparam logic [WCNT_W-1:0] INIT_LOAD = WCNT_W'(INIT_WAIT - 1);
  localparam logic [WCNT_W-1:0] RST_LOAD  = WCNT_W'(RST_WAIT - 1);
  localparam logic [7:0]        LAST_I    = 8'(NUM_ITER - 1);
  localparam logic [LFSR_W-1:0] SEED_EFF  = (LFSR_SEED == '0) ? LFSR_W'(1) : LFSR_SEED;

  stim_state_t       state, state_n;
  logic [WCNT_W-1:0] wcnt, wcnt_n;
  logic [DLY_W-1:0]  dly, dly_n;
  logic [7:0]        i, i_n;
  logic              d_n, en_n, rstn_n, busy_n, done_n;
  logic              clr_chk;
  logic              lfsr_adv;
  logic [LFSR_W-1:0] lfsr;
  logic              unused_lfsr_hi;
  logic              qhold, qexp;

  lfsr16 u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load_val (SEED_EFF),
    .adv      (lfsr_adv),
    .value    (lfsr)
  );

  assign lfsr_adv       = (state == S_DRAW);
  assign unused_lfsr_hi = ^lfsr[LFSR_W-1:DLY2_W+DLY_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      wcnt  <= '0;
      dly   <= '0;
      i     <= '0;
      d     <= 1'b0;
      en    <= 1'b0;
      rstn  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      wcnt  <= wcnt_n;
      dly   <= dly_n;
      i     <= i_n;
      d     <= d_n;
      en    <= en_n;
      rstn  <= rstn_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

  // wcnt serves as the INIT/RELEASE timer and then as the dly2 / dly down-counter.
  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    dly_n   = dly;
    i_n     = i;
    d_n     = d;
    en_n    = en;
    rstn_n  = rstn;
    busy_n  = busy;
    done_n  = done;
    clr_chk = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n = S_INIT;
          wcnt_n  = INIT_LOAD;
          i_n     = '0;
          d_n     = 1'b0;
          en_n    = 1'b0;
          rstn_n  = 1'b0;
          busy_n  = 1'b1;
          done_n  = 1'b0;
          clr_chk = 1'b1;
        end
      end
      S_INIT: begin
        if (wcnt == '0) begin
          state_n = S_RELEASE;
          wcnt_n  = RST_LOAD;
        end else begin
          wcnt_n = wcnt - WCNT_W'(1);
        end
      end
      S_RELEASE: begin
        if (wcnt == '0) begin
          state_n = S_DRAW;
          rstn_n  = 1'b1;
        end else begin
          wcnt_n = wcnt - WCNT_W'(1);
        end
      end
      S_DRAW: begin
        wcnt_n  = WCNT_W'(lfsr[DLY2_W-1:0]);
        dly_n   = lfsr[DLY2_W +: DLY_W];
        state_n = S_WAIT_EN;
      end
      S_WAIT_EN: begin
        if (wcnt == '0) begin
          en_n    = ~en;
          wcnt_n  = WCNT_W'(dly);
          state_n = S_WAIT_D;
        end else begin
          wcnt_n = wcnt - WCNT_W'(1);
        end
      end
      S_WAIT_D: begin
        if (wcnt == '0) begin
          d_n = i[0];
          i_n = i + 8'd1;
          if (i == LAST_I) begin
            state_n = S_DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            state_n = S_DRAW;
          end
        end else begin
          wcnt_n = wcnt - WCNT_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Reference latch: transparent view of the current registered drive, with qhold as its memory.
  assign qexp = !rstn ? 1'b0 : (en ? d : qhold);

  always_ff @(posedge clk) begin
    if (rst) begin
      qhold     <= 1'b0;
      mismatch  <= 1'b0;
      err_count <= '0;
    end else begin
      qhold <= qexp;
      if (clr_chk) begin
        mismatch  <= 1'b0;
        err_count <= '0;
      end else if (busy && rstn && (q != qexp)) begin
        mismatch <= 1'b1;
        if (err_count != '1) begin
          err_count <= err_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_latch_stim_gen.sv
// Bench for latch_stim_gen: per-cycle expectation tables built from an
// independent event-time model, plus reset, replay and saturation sequences.
module tb_latch_stim_gen;

  localparam int          NITER = 5;
  localparam int          INITW = 10;
  localparam int          RSTW  = 10;
  localparam logic [15:0] SEED  = 16'hACE1;
  localparam int          MAXV  = 160;

  logic       clk = 1'b0;
  logic       rst, start, qforce, lq, q;
  logic       d, en, rstn, busy, done, mismatch;
  logic [7:0] err_count;
  logic       start2, d2, en2, rstn2, busy2, done2, mis2;
  logic [7:0] err2;

  always #5 clk = ~clk;

  // Behavioural dlatch1 stand-in driven by the DUT.
  always_latch begin
    if (!rstn) lq <= 1'b0;
    else if (en) lq <= d;
  end
  assign q = qforce ? 1'b1 : lq;

  latch_stim_gen #(.NUM_ITER(NITER), .INIT_WAIT(INITW), .RST_WAIT(RSTW), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .start(start), .q(q), .d(d), .en(en), .rstn(rstn),
    .busy(busy), .done(done), .mismatch(mismatch), .err_count(err_count)
  );

  latch_stim_gen #(.NUM_ITER(255), .INIT_WAIT(3), .RST_WAIT(2), .LFSR_SEED(16'h0000)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .q(1'b1), .d(d2), .en(en2), .rstn(rstn2),
    .busy(busy2), .done(done2), .mismatch(mis2), .err_count(err2)
  );

  typedef struct {
    logic       start;
    logic       ed, een, erstn, ebusy, edone, emis;
    logic [7:0] eerr;
  } vec_t;

  vec_t        vecs [MAXV];
  int          nvec;
  int          ev_ten [NITER];
  int          ev_td  [NITER];
  logic [15:0] mlfsr;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [15:0] mstep(input logic [15:0] v);
    if (v[0]) return (v >> 1) ^ 16'hB400;
    return v >> 1;
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // Expected outputs after each edge k of a run; edge 0 samples start.
  task automatic build(input logic qf, input logic extra_start);
    int t, done_e, errc;
    logic qh, qm, den, dd, drstn, dbusy;
    logic [1:0] dly2v;
    logic [2:0] dlyv;
    t = INITW + RSTW;
    for (int it = 0; it < NITER; it++) begin
      dly2v = mlfsr[1:0];
      dlyv  = mlfsr[4:2];
      mlfsr = mstep(mlfsr);
      ev_ten[it] = t + 2 + int'(dly2v);
      ev_td[it]  = ev_ten[it] + int'(dlyv) + 1;
      t = ev_td[it];
    end
    done_e = t;
    nvec   = done_e + 3;
    errc   = 0;
    qh     = 1'b0;
    for (int k = 0; k < nvec; k++) begin
      den = 1'b0;
      dd  = 1'b0;
      for (int it = 0; it < NITER; it++) begin
        if (ev_ten[it] <= k) den = ~den;
        if (ev_td[it] <= k) dd = it[0];
      end
      drstn = (k >= INITW + RSTW);
      dbusy = (k < done_e);
      vecs[k].start = (k == 0) || (extra_start && (k == 5 || k == done_e - 1));
      vecs[k].ed    = dd;
      vecs[k].een   = den;
      vecs[k].erstn = drstn;
      vecs[k].ebusy = dbusy;
      vecs[k].edone = !dbusy;
      vecs[k].emis  = (errc != 0);
      vecs[k].eerr  = 8'(errc);
      qm = !drstn ? 1'b0 : (den ? dd : qh);
      qh = qm;
      if (dbusy && drstn && qf && !qm && errc < 255) errc++;
    end
  endtask

  task automatic run_vecs(input logic qf, input int upto, input string tag);
    qforce = qf;
    for (int k = 0; k < upto; k++) begin
      start = vecs[k].start;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("%s[%0d] {d,en,rstn,busy,done,mis,err}", tag, k),
          {2'b00, d, en, rstn, busy, done, mismatch, err_count},
          {2'b00, vecs[k].ed, vecs[k].een, vecs[k].erstn, vecs[k].ebusy,
           vecs[k].edone, vecs[k].emis, vecs[k].eerr});
    end
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start2 = 1'b0; qforce = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset outputs", {2'b00, d, en, rstn, busy, done, mismatch, err_count}, 16'h0000);
    chk("reset lfsr", dut.u_lfsr.value, 16'hACE1);
    chk("reset lfsr zero seed", dut2.u_lfsr.value, 16'h0001);
    chk("reset dut2 outputs", {2'b00, d2, en2, rstn2, busy2, done2, mis2, err2}, 16'h0000);
    rst = 1'b0;

    // A: real latch, from seed, with start pulses while busy that must be ignored.
    mlfsr = SEED;
    build(1'b0, 1'b1);
    run_vecs(1'b0, nvec, "A");
    // B: restart from DONE with q stuck at 1; LFSR stream continues.
    build(1'b1, 1'b0);
    run_vecs(1'b1, nvec, "B");
    // C: restart from DONE with real latch; error state must clear.
    build(1'b0, 1'b0);
    run_vecs(1'b0, nvec, "C");

    // D: reset during WAIT_EN of iteration 2, then replay from seed.
    build(1'b0, 1'b0);
    run_vecs(1'b0, ev_td[1] + 2, "D");
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid-run reset outputs", {2'b00, d, en, rstn, busy, done, mismatch, err_count}, 16'h0000);
    chk("mid-run reset lfsr", dut.u_lfsr.value, SEED);
    rst = 1'b0;
    mlfsr = SEED;
    build(1'b0, 1'b0);
    run_vecs(1'b0, nvec, "E");

    // dut2: short waits, zero seed, 255 iterations, q stuck at 1 -> saturation.
    start2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start2 = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 4) chk("dut2 rstn low at edge 4", {15'd0, rstn2}, 16'd0);
      if (k == 5) chk("dut2 rstn high at edge 5", {15'd0, rstn2}, 16'd1);
      if (k == 6) chk("dut2 first error", {7'd0, mis2, err2}, 16'h0101);
    end
    for (int c = 0; c < 5000 && !done2; c++) @(negedge clk);
    chk("dut2 done within budget", {15'd0, done2}, 16'd1);
    chk("dut2 busy low", {15'd0, busy2}, 16'd0);
    chk("dut2 err_count saturated", {8'd0, err2}, 16'd255);
    chk("dut2 mismatch sticky", {15'd0, mis2}, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
